// File: rtl/control_seq.sv
// Control sequencer for the 16-bit CPU datapath: fetch/decode/execute FSM driving
// datapath strobes and the memory read/write handshake.
module control_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] isr,
  input  logic        mem_ready,
  output logic [2:0]  funsel,
  output logic [2:0]  rsel,
  output logic        lsp,
  output logic        lpc,
  output logic        lmdr,
  output logic        lmar,
  output logic        lisr,
  output logic        ly,
  output logic        wrr,
  output logic        spmar,
  output logic        pcmar,
  output logic        mdrz,
  output logic        mdrm,
  output logic        tr,
  output logic        tsp,
  output logic        tpc,
  output logic        tmdr,
  output logic        tisr,
  output logic        sflag,
  output logic        cc,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_FETCH0 = 5'd0,  S_FETCH1 = 5'd1,  S_FETCH2 = 5'd2,  S_DECODE = 5'd3,
    S_BR0    = 5'd4,  S_BR1    = 5'd5,  S_AL0    = 5'd6,  S_AL1    = 5'd7,
    S_PU0    = 5'd8,  S_PU1    = 5'd9,  S_PU2    = 5'd10, S_PO0    = 5'd11,
    S_PO1    = 5'd12, S_PO2    = 5'd13, S_LI0    = 5'd14, S_LI1    = 5'd15,
    S_LI2    = 5'd16, S_HALT   = 5'd17
  } state_t;

  state_t cur;

  logic [3:0] op;
  logic [2:0] alu_fn;
  logic [2:0] rd;
  logic [2:0] rs;
  logic       unused_isr;

  assign op         = isr[15:12];
  assign alu_fn     = isr[11:9];
  assign rd         = isr[8:6];
  assign rs         = isr[5:3];
  assign unused_isr = &isr[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH0;
    end else begin
      case (cur)
        S_FETCH0: cur <= S_FETCH1;
        S_FETCH1: if (mem_ready) cur <= S_FETCH2;
        S_FETCH2: cur <= S_DECODE;
        S_DECODE: begin
          case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8: cur <= S_BR0;
            4'd9:                   cur <= S_AL0;
            4'd10:                  cur <= S_PU0;
            4'd11:                  cur <= S_PO0;
            4'd12:                  cur <= S_LI0;
            4'd15:                  cur <= S_HALT;
            default:                cur <= S_FETCH0;
          endcase
        end
        S_BR0:  cur <= S_BR1;
        S_BR1:  cur <= S_FETCH0;
        S_AL0:  cur <= S_AL1;
        S_AL1:  cur <= S_FETCH0;
        S_PU0:  cur <= S_PU1;
        S_PU1:  cur <= S_PU2;
        S_PU2:  if (mem_ready) cur <= S_FETCH0;
        S_PO0:  cur <= S_PO1;
        S_PO1:  if (mem_ready) cur <= S_PO2;
        S_PO2:  cur <= S_FETCH0;
        S_LI0:  cur <= S_LI1;
        S_LI1:  if (mem_ready) cur <= S_LI2;
        S_LI2:  cur <= S_FETCH0;
        S_HALT: cur <= S_HALT;
        default: cur <= S_FETCH0;
      endcase
    end
  end

  // Moore decode of the state register; reset overrides everything combinationally
  // so the datapath sees no strobes even when reset lands mid-instruction.
  always_comb begin
    funsel = '0;  rsel  = '0;
    lsp    = 1'b0; lpc   = 1'b0; lmdr = 1'b0; lmar   = 1'b0; lisr   = 1'b0;
    ly     = 1'b0; wrr   = 1'b0; spmar = 1'b0; pcmar = 1'b0; mdrz   = 1'b0;
    mdrm   = 1'b0; tr    = 1'b0; tsp  = 1'b0; tpc    = 1'b0; tmdr   = 1'b0;
    tisr   = 1'b0; sflag = 1'b0; cc   = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    halted = 1'b0;
    state  = '0;
    if (!reset) begin
      state = cur;
      case (cur)
        S_FETCH0, S_LI0: begin
          pcmar = 1'b1; lmar = 1'b1;
        end
        S_FETCH1, S_LI1: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            mdrm = 1'b1; lmdr = 1'b1; tpc = 1'b1; funsel = 3'd6; lpc = 1'b1;
          end
        end
        S_FETCH2: lisr = 1'b1;
        S_BR0: begin
          tpc = 1'b1; ly = 1'b1;
        end
        S_BR1: begin
          tisr = 1'b1; funsel = 3'd2; lpc = 1'b1; cc = 1'b1;
        end
        S_AL0: begin
          tr = 1'b1; rsel = rs; ly = 1'b1;
        end
        S_AL1: begin
          tr = 1'b1; rsel = rd; funsel = alu_fn; wrr = 1'b1; sflag = 1'b1;
        end
        S_PU0: begin
          tsp = 1'b1; funsel = 3'd7; lsp = 1'b1;
        end
        S_PU1: begin
          spmar = 1'b1; lmar = 1'b1; tr = 1'b1; rsel = rd; funsel = 3'd1;
          mdrz = 1'b1; lmdr = 1'b1;
        end
        S_PU2: mem_wr = 1'b1;
        S_PO0: begin
          spmar = 1'b1; lmar = 1'b1;
        end
        S_PO1: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            mdrm = 1'b1; lmdr = 1'b1; tsp = 1'b1; funsel = 3'd6; lsp = 1'b1;
          end
        end
        S_PO2, S_LI2: begin
          tmdr = 1'b1; funsel = 3'd1; rsel = rd; wrr = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_seq.md
# control_seq

Microcoded-style control sequencer for the 16-bit accumulator-less CPU datapath. It sits directly upstream of `datapath` and drives every load, tri-state, ALU-function and register-select strobe that the datapath consumes. It also owns the memory read/write handshake and runs the fetch, decode and execute sequence from the instruction word held in the datapath's ISR.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clock clk
- isr  in  16  instruction register value from datapath
- mem_ready  in  1  memory completes current rd/wr this cycle
- funsel  out  3  ALU function: 1 pass, 2 add, 3 neg, 4 or, 5 not, 6 inc, 7 dec
- rsel  out  3  register bank select
- lsp, lpc, lmdr, lmar, lisr, ly, wrr  out  1 each  register load strobes
- spmar, pcmar, mdrz, mdrm  out  1 each  MAR/MDR input mux selects
- tr, tsp, tpc, tmdr, tisr  out  1 each  x-bus drivers; at most one high per cycle
- sflag  out  1  update flags from ALU this cycle
- cc  out  1  gate lpc with condition (branch only)
- mem_rd, mem_wr  out  1 each  memory request, address=MAR, wdata=MDR
- halted  out  1  HALT executed
- state  out  5  current state, for debug

## Operation
- Instruction format:
  - isr[15:12] 0–8: relative branch. Condition code 0 = always, 1–8 = flag tests. Offset is sign-extended isr[11:0], added to the already-incremented PC.
  - 9 ALU: isr[11:9]=funsel, [8:6]=rd, [5:3]=rs.
  - 10 PUSH rd; 11 POP rd; 12 LDI rd (next word); 13, 14 NOP; 15 HALT.
- Default: every output 0 unless listed.
- States and asserted outputs:
  - FETCH0: pcmar, lmar.
  - FETCH1: mem_rd. When mem_ready: mdrm, lmdr, tpc, funsel=6, lpc.
  - FETCH2: lisr.
  - DECODE: no strobes; dispatch on isr[15:12].
  - BR0: tpc, ly.
  - BR1: tisr, funsel=2, lpc, cc.
  - AL0: tr, rsel=rs, ly.
  - AL1: tr, rsel=rd, funsel=isr[11:9], wrr, sflag.
  - PU0: tsp, funsel=7, lsp.
  - PU1: spmar, lmar, tr, rsel=rd, funsel=1, mdrz, lmdr.
  - PU2: mem_wr.
  - PO0: spmar, lmar.
  - PO1: mem_rd. When mem_ready: mdrm, lmdr, tsp, funsel=6, lsp.
  - PO2: tmdr, funsel=1, rsel=rd, wrr.
  - LI0: pcmar, lmar.
  - LI1: same as FETCH1.
  - LI2: same as PO2.
  - HALT: halted=1.
- Transitions:
  - FETCH0→FETCH1→FETCH2→DECODE.
  - DECODE → BR0 / AL0 / PU0 / PO0 / LI0 / FETCH0 (NOP) / HALT.
  - BR1, AL1, PO2, LI2 → FETCH0.
  - PU0→PU1→PU2. PU2→FETCH0 on mem_ready.
  - Wait states FETCH1, PO1, LI1, PU2 hold while mem_ready=0. Strobes gated by mem_ready are suppressed while waiting; mem_rd/mem_wr stay high.
  - HALT is terminal until reset.
- The sequencer does not evaluate the branch condition itself. It always asserts cc in BR1; the datapath gates lpc.
- Stack grows downward: pre-decrement on push, post-increment on pop.

## Timing
- Moore outputs decoded from the state register. The only exception is the mem_ready-qualified strobes in wait states, which are combinational from mem_ready.
- State register updates on the rising clk edge.
- reset=1 at an edge: next state FETCH0, halted=0. While reset is high all outputs are forced 0, including mid-instruction and mid-wait.
- First cycle after reset release: FETCH0.
- Latency with mem_ready tied 1:
  - fetch+decode: 4 cycles.
  - NOP: 4 total.
  - BR and ALU: 6.
  - PUSH, POP, LDI: 7.
  - Each mem_ready=0 cycle adds 1.
- Invariants: at most one x-bus driver; spmar and pcmar never both high; mdrz and mdrm never both high; mem_rd and mem_wr never both high.
- An unused ALU funsel of 0 passes through unchanged; the datapath yields z=0.

## Test plan
- Reset, mem_ready=1, memory returns 0xE000 (NOP):
  - FETCH0 asserts pcmar=lmar=1.
  - FETCH1 asserts mdrm, lmdr, tpc, funsel=6, lpc.
  - Back in FETCH0 4 cycles after FETCH0.
- isr=0x9450 (ADD r1,r2):
  - AL0: tr=1, rsel=2, ly=1.
  - AL1: tr=1, rsel=1, funsel=2, wrr=1, sflag=1.
  - Then FETCH0.
- isr=0x1005 (conditional branch):
  - BR0: tpc, ly.
  - BR1: tisr=1, funsel=2, lpc=1, cc=1.
  - Total 6 cycles.
- isr=0xA0C0 (PUSH r3), mem_ready low 3 cycles in PU2:
  - PU0: tsp, funsel=7, lsp.
  - PU1: spmar, lmar, tr, rsel=3, mdrz, lmdr.
  - mem_wr high 4 cycles with no other strobes; FETCH0 after mem_ready=1.
- isr=0xB080 (POP r2), mem_ready low 2 cycles in PO1:
  - lmdr and lsp pulse only in the mem_ready=1 cycle.
  - PO2: tmdr, wrr, rsel=2.
- isr=0xF000 → HALT: halted=1 held for 10 cycles, no strobes.
- Reset asserted during PU2 wait: all outputs 0 immediately, FETCH0 next cycle, halted=0.
